// File: rtl/pixel_line_buffer_pkg.sv
// Shared defaults, pixel type, FSM encoding and width helper for the pixel line buffer.
package pixel_line_buffer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CHANNELS   = 3;
    localparam int unsigned DEF_LINES      = 3;
    localparam int unsigned DEF_MAX_WIDTH  = 200;

    typedef logic [DEF_CHANNELS*DEF_DATA_WIDTH-1:0] pixel_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_PRIME  = 2'd1;
    localparam state_t ST_STREAM = 2'd2;

    // A zero or oversized request falls back to the full RAM depth.
    function automatic logic [15:0] eff_width(input logic [15:0] cfg, input logic [15:0] max_w);
        return (cfg == 16'd0 || cfg > max_w) ? max_w : cfg;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line store: write on the clock edge, read returns the pre-write contents.
module line_ram #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned DEPTH      = 200,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pixel_line_buffer.sv
// Vertical tap generator: cascaded line RAMs deliver one column of LINES pixels per input pixel.
module pixel_line_buffer
    import pixel_line_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CHANNELS   = DEF_CHANNELS,
    parameter int unsigned LINES      = DEF_LINES,
    parameter int unsigned MAX_WIDTH  = DEF_MAX_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [15:0]                          cfg_width,
    input  logic                                 s_valid,
    input  logic                                 s_sof,
    input  logic                                 s_eol,
    input  logic [CHANNELS*DATA_WIDTH-1:0]       s_data,
    output logic                                 m_valid,
    output logic [LINES*CHANNELS*DATA_WIDTH-1:0] m_taps,
    output logic [15:0]                          m_col,
    output logic                                 m_eol,
    output logic                                 err_len
);

    localparam int unsigned PW = CHANNELS * DATA_WIDTH;
    localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int unsigned LW = $clog2(LINES);
    localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);
    localparam logic [LW-1:0] LAST_PRIME = LW'(LINES - 1);

    state_t                  state_q, state_d, cur_state;
    logic [15:0]             col_q, col_d, cur_col;
    logic [15:0]             width_q, width_d, cur_width;
    logic [LW-1:0]           lines_q, lines_d, cur_lines, lines_inc;
    logic                    err_q, err_d;
    logic                    m_valid_q, m_valid_d, m_eol_q, m_eol_d;
    logic [15:0]             m_col_q, m_col_d;
    logic [LINES*PW-1:0]     m_taps_q, m_taps_d;
    logic                    accept, at_last, eol_in, line_end, err_set;
    logic [AW-1:0]           ram_addr;
    logic [PW-1:0]           ram_rd [LINES-1];
    logic [PW-1:0]           ram_wr [LINES-1];

    // s_sof restarts the frame in the same cycle, so it overrides the registered context.
    always_comb begin
        accept    = s_valid && (s_sof || state_q != ST_IDLE);
        cur_state = s_sof ? ST_PRIME : state_q;
        cur_col   = s_sof ? 16'd0 : col_q;
        cur_width = s_sof ? eff_width(cfg_width, MAX_W) : width_q;
        cur_lines = s_sof ? '0 : lines_q;
        lines_inc = cur_lines + LW'(1);
        at_last   = (cur_col == cur_width - 16'd1);
        eol_in    = s_eol && !s_sof;
        line_end  = eol_in || at_last;
        err_set   = eol_in != at_last;
        ram_addr  = cur_col[AW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        width_d   = width_q;
        lines_d   = lines_q;
        err_d     = err_q;
        m_valid_d = m_valid_q;
        m_eol_d   = m_eol_q;
        m_col_d   = m_col_q;
        m_taps_d  = m_taps_q;
        if (accept) begin
            state_d   = cur_state;
            width_d   = cur_width;
            lines_d   = cur_lines;
            col_d     = line_end ? 16'd0 : cur_col + 16'd1;
            err_d     = (s_sof ? 1'b0 : err_q) | err_set;
            m_valid_d = (cur_state == ST_STREAM);
            m_eol_d   = line_end;
            m_col_d   = cur_col;
            if (line_end && cur_state == ST_PRIME) begin
                lines_d = (cur_lines == LAST_PRIME) ? cur_lines : lines_inc;
                if (lines_inc == LAST_PRIME) begin
                    state_d = ST_STREAM;
                end
            end
            // Taps stay zero until primed so stale RAM contents never leak out.
            m_taps_d = '0;
            if (cur_state == ST_STREAM) begin
                m_taps_d[PW-1:0] = s_data;
                for (int k = 1; k < int'(LINES); k++) begin
                    m_taps_d[k*PW +: PW] = ram_rd[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_q     <= 16'd0;
            width_q   <= MAX_W;
            lines_q   <= '0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_eol_q   <= 1'b0;
            m_col_q   <= 16'd0;
            m_taps_q  <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            width_q   <= width_d;
            lines_q   <= lines_d;
            err_q     <= err_d;
            m_valid_q <= m_valid_d;
            m_eol_q   <= m_eol_d;
            m_col_q   <= m_col_d;
            m_taps_q  <= m_taps_d;
        end
    end

    for (genvar k = 0; k < int'(LINES) - 1; k++) begin : g_ram
        if (k == 0) begin : g_head
            assign ram_wr[k] = s_data;
        end else begin : g_chain
            assign ram_wr[k] = ram_rd[k-1];
        end
        line_ram #(
            .WIDTH      (PW),
            .DEPTH      (MAX_WIDTH),
            .ADDR_WIDTH (AW)
        ) u_line_ram (
            .clk   (clk),
            .we    (accept),
            .addr  (ram_addr),
            .wdata (ram_wr[k]),
            .rdata (ram_rd[k])
        );
    end

    assign m_valid = m_valid_q;
    assign m_taps  = m_taps_q;
    assign m_col   = m_col_q;
    assign m_eol   = m_eol_q;
    assign err_len = err_q;

endmodule

// File: tb/tb_pixel_line_buffer.sv
// Directed bench for pixel_line_buffer with default parameters (8-bit, 3 channels, 3 lines, 200 deep).
module tb_pixel_line_buffer;
    import pixel_line_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_width;
    logic        s_valid, s_sof, s_eol;
    pixel_t      s_data;
    logic        m_valid, m_eol, err_len;
    logic [71:0] m_taps;
    logic [15:0] m_col;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pixel_line_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_width (cfg_width),
        .s_valid   (s_valid),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_taps    (m_taps),
        .m_col     (m_col),
        .m_eol     (m_eol),
        .err_len   (err_len)
    );

    function automatic pixel_t pix(input logic [7:0] v);
        return {v + 8'h80, v + 8'h40, v};
    endfunction

    // Slice 0 (LSBs) is the current line, slice 2 the line two rows earlier.
    function automatic logic [71:0] taps3(input logic [7:0] cur, input logic [7:0] up1,
                                          input logic [7:0] up2);
        return {pix(up2), pix(up1), pix(cur)};
    endfunction

    task automatic drive(input logic sof, input logic eol, input logic [7:0] v);
        @(negedge clk);
        s_valid = 1'b1;
        s_sof   = sof;
        s_eol   = eol;
        s_data  = pix(v);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({m_valid, m_eol, err_len, m_col, m_taps} !== 91'd0) begin
            tests_failed++;
            $display("FAIL reset: got v=%b eol=%b err=%b col=%0d taps=%h, expected all zero",
                     m_valid, m_eol, err_len, m_col, m_taps);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle_discard();
        drive(1'b0, 1'b1, 8'h55);
        drive(1'b0, 1'b0, 8'h66);
        tests_run++;
        if ({m_valid, m_eol, err_len, m_col, m_taps} !== 91'd0) begin
            tests_failed++;
            $display("FAIL idle_discard: got v=%b eol=%b err=%b col=%0d taps=%h, expected all zero",
                     m_valid, m_eol, err_len, m_col, m_taps);
        end
    endtask

    // Four 4-pixel rows, pixel = row*16+col; with gap>0 the held outputs are rechecked.
    task automatic run_ramp(input int gap, input string tag);
        logic [7:0]  v;
        logic [89:0] exp_t, obs_t;
        cfg_width = 16'd4;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = 8'(r * 16 + c);
                drive(r == 0 && c == 0, c == 3, v);
                exp_t = {r >= 2, c == 3, 16'(c),
                         (r >= 2) ? taps3(v, v - 8'd16, v - 8'd32) : 72'd0};
                obs_t = {m_valid, m_eol, m_col, m_taps};
                tests_run++;
                if (obs_t !== exp_t) begin
                    tests_failed++;
                    $display("FAIL %s r%0d c%0d: got %h expected %h", tag, r, c, obs_t, exp_t);
                end
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                    obs_t = {m_valid, m_eol, m_col, m_taps};
                    tests_run++;
                    if (obs_t !== exp_t) begin
                        tests_failed++;
                        $display("FAIL %s_hold r%0d c%0d: got %h expected %h",
                                 tag, r, c, obs_t, exp_t);
                    end
                end
            end
        end
        tests_run++;
        if (err_len !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_err: got err_len=%b expected 0", tag, err_len);
        end
    endtask

    task automatic test_ramp();
        run_ramp(0, "ramp");
    endtask

    task automatic test_gaps();
        run_ramp(3, "gaps");
    endtask

    task automatic test_short_eol();
        cfg_width = 16'd4;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h01);
        drive(1'b0, 1'b1, 8'h02);
        tests_run++;
        if ({err_len, m_eol, m_col} !== {1'b1, 1'b1, 16'd2}) begin
            tests_failed++;
            $display("FAIL short_eol: got err=%b eol=%b col=%0d expected err=1 eol=1 col=2",
                     err_len, m_eol, m_col);
        end
        drive(1'b0, 1'b0, 8'h10);
        tests_run++;
        if ({err_len, m_eol, m_col} !== {1'b1, 1'b0, 16'd0}) begin
            tests_failed++;
            $display("FAIL short_eol_next: got err=%b eol=%b col=%0d expected err=1 eol=0 col=0",
                     err_len, m_eol, m_col);
        end
        drive(1'b1, 1'b0, 8'h00);
        tests_run++;
        if (err_len !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_eol_clear: got err_len=%b expected 0", err_len);
        end
    endtask

    task automatic test_no_eol();
        cfg_width = 16'd4;
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 1'b0, 8'(c));
            tests_run++;
            if ({m_eol, m_col} !== {c == 3, 16'(c % 4)}) begin
                tests_failed++;
                $display("FAIL no_eol c%0d: got eol=%b col=%0d expected eol=%b col=%0d",
                         c, m_eol, m_col, c == 3, c % 4);
            end
        end
        tests_run++;
        if (err_len !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_eol_err: got err_len=%b expected 1", err_len);
        end
    endtask

    task automatic test_sof_eol();
        logic [7:0]  v;
        logic [89:0] obs_t;
        cfg_width = 16'd4;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(r == 0 && c == 0, c == 3, 8'(r * 16 + c));
            end
        end
        drive(1'b0, 1'b0, 8'h20);
        tests_run++;
        if (m_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sof_eol_primed: got m_valid=%b expected 1", m_valid);
        end
        // Restart mid-row with s_sof and s_eol together: new frame row 0, col 0.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = 8'h80 + 8'(r * 16 + c);
                drive(r == 0 && c == 0, (r == 0 && c == 0) || c == 3, v);
                obs_t = {m_valid, m_eol, m_col, m_taps};
                tests_run++;
                if (obs_t !== {r == 2, c == 3, 16'(c),
                               (r == 2) ? taps3(v, v - 8'd16, v - 8'd32) : 72'd0}) begin
                    tests_failed++;
                    $display("FAIL sof_eol r%0d c%0d: got %h", r, c, obs_t);
                end
            end
        end
        tests_run++;
        if (err_len !== 1'b0) begin
            tests_failed++;
            $display("FAIL sof_eol_err: got err_len=%b expected 0", err_len);
        end
    endtask

    task automatic test_rst_mid();
        cfg_width = 16'd4;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r == 3 && c == 1) break;
                drive(r == 0 && c == 0, c == 3, 8'(r * 16 + c));
            end
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({m_valid, m_eol, err_len, m_col, m_taps} !== 91'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: got v=%b eol=%b err=%b col=%0d taps=%h, expected all zero",
                     m_valid, m_eol, err_len, m_col, m_taps);
        end
        @(negedge clk);
        rst = 1'b0;
        // cfg_width 0 selects the full 200-pixel line; lines end by wrap only.
        cfg_width = 16'd0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 200; c++) begin
                drive(r == 0 && c == 0, 1'b0, (c == 0) ? 8'(r * 16) : 8'(c));
                if (c >= 198) begin
                    tests_run++;
                    if ({m_valid, m_eol} !== {1'b0, c == 199}) begin
                        tests_failed++;
                        $display("FAIL w200 r%0d c%0d: got v=%b eol=%b expected v=0 eol=%b",
                                 r, c, m_valid, m_eol, c == 199);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 8'h20);
        tests_run++;
        if ({m_valid, m_col, m_taps} !== {1'b1, 16'd0, taps3(8'h20, 8'h10, 8'h00)}) begin
            tests_failed++;
            $display("FAIL w200_taps: got v=%b col=%0d taps=%h expected v=1 col=0 taps=%h",
                     m_valid, m_col, m_taps, taps3(8'h20, 8'h10, 8'h00));
        end
        cfg_width = 16'd500;
        for (int c = 0; c < 200; c++) begin
            drive(c == 0, 1'b0, 8'(c));
            if (c >= 198) begin
                tests_run++;
                if ({m_valid, m_eol, m_col} !== {1'b0, c == 199, 16'(c)}) begin
                    tests_failed++;
                    $display("FAIL w500 c%0d: got v=%b eol=%b col=%0d expected v=0 eol=%b col=%0d",
                             c, m_valid, m_eol, m_col, c == 199, c);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        cfg_width = 16'd0;
        s_valid   = 1'b0;
        s_sof     = 1'b0;
        s_eol     = 1'b0;
        s_data    = '0;
        test_reset();
        test_idle_discard();
        test_ramp();
        test_gaps();
        test_short_eol();
        test_no_eol();
        test_sof_eol();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
